seq_shift_add_multiplier: RTL

Sequential unsigned shift-and-add multiplier. It is the inverse operation of the team's restoring divider: WIDTH-bit multiplicand times WIDTH-bit multiplier gives a 2*WIDTH-bit product. The controller FSM and datapath (operand register, accumulator/shift register, adder, down-counter) live in one block. It uses a Start/Done handshake so that it can sit beside the divider in the arithmetic unit.

---
 rtl/seq_shift_add_multiplier_if.sv | 22 ++
 rtl/seq_shift_add_multiplier.sv | 120 ++++++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// Start/Done handshake bundle for the sequential shift-and-add multiplier.
// The master issues operands and Start; the slave returns Product, Ready and Done.
interface seq_shift_add_multiplier_if #(
  parameter int WIDTH = 5
);
  logic               Start;
  logic [WIDTH-1:0]   Multiplicand;
  logic [WIDTH-1:0]   Multiplier;
  logic [2*WIDTH-1:0] Product;
  logic               Ready;
  logic               Done;

  modport master (
    output Start, Multiplicand, Multiplier,
    input  Product, Ready, Done
  );

  modport slave (
    input  Start, Multiplicand, Multiplier,
    output Product, Ready, Done
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH.
// One partial-product iteration per clock, WIDTH iterations per operation,
// with a Moore IDLE/CALC/DONE controller and a Start/Done handshake that
// matches the restoring divider it sits beside.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 5
) (
  input logic                    CLK,
  input logic                    RST_N,
  seq_shift_add_multiplier_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               ready;
  logic               done;

  // Latched multiplicand, {carry, upper, lower} shift register, iteration count
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH:0]   shreg;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH:0]   shreg_step;

  // One iteration: conditionally add the multiplicand into the upper half at
  // WIDTH+1 bits, then shift {carry, upper, lower} right with the carry
  // entering the MSB. The bit shifted out of lower is the consumed multiplier bit.
  function automatic logic [2*WIDTH:0] shift_add_step(
    input logic [2*WIDTH:0] sr,
    input logic [WIDTH-1:0] a
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, sr[2*WIDTH-1:WIDTH]};
    if (sr[0]) begin
      sum = sum + {1'b0, a};
    end
    return {1'b0, sum, sr[WIDTH-1:1]};
  endfunction

  assign shreg_step = shift_add_step(shreg, opnd);

  // Controller state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and Moore outputs decoded from the current state
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.Start) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: load operands on accept, iterate in CALC, capture the product
  // on the final iteration so it is visible exactly while Done is high
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      opnd    <= '0;
      shreg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            opnd  <= bus.Multiplicand;
            shreg <= {{(WIDTH + 1){1'b0}}, bus.Multiplier};
            cnt   <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          shreg <= shreg_step;
          cnt   <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            product <= shreg_step[2*WIDTH-1:0];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.Product = product;
  assign bus.Ready   = ready;
  assign bus.Done    = done;

endmodule
